// File: rtl/hdlbc_dec_core.sv
// ---------------------------------------------------------------------------
// hdlbc_dec_core
//
// Iterative 64-bit block decryptor. One inverse round is applied per clock
// cycle, and round keys are consumed in descending order (ROUNDS-1 down to 0).
// The round keys come from an external key schedule. This block drives
// rk_idx, and the schedule must return the matching rk combinationally in
// the same cycle.
//
// Bit 0 of every vector is the MSB. The 64-bit state is split into four
// 16-bit words: W0=[0:15], W1=[16:31], W2=[32:47], W3=[48:63].
//
// Ports
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous active-high reset
//   start   in   1      start a decryption of cin (sampled only in IDLE)
//   cin     in   [0:63] ciphertext block
//   rk_idx  out  [0:4]  round key index required this cycle (0 outside RUN)
//   rk      in   [0:15] round key for rk_idx
//   busy    out  1      high in RUN and DONE
//   done    out  1      one-cycle pulse while pout carries a new result
//   pout    out  [0:63] plaintext, held until the next completed decryption
// ---------------------------------------------------------------------------
module hdlbc_dec_core #(
    parameter int ROUNDS = 24   // legal range 1..32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [0:63] cin,
    output logic [0:4]  rk_idx,
    input  logic [0:15] rk,
    output logic        busy,
    output logic        done,
    output logic [0:63] pout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:4] LAST_IDX = 5'(ROUNDS - 1);

    state_t      state, state_nxt;
    logic [0:4]  cnt, cnt_nxt;
    logic [0:63] blk, blk_nxt;
    logic [0:63] pout_nxt;

    // -----------------------------------------------------------------------
    // Inverse round: (W0,W1,W2,W3) -> (W1, W0^F, W3, W2^F), where F uses the
    // same A/C words the forward round used. Those words travel through
    // unchanged as W1/W3, which is what makes the round invertible.
    // -----------------------------------------------------------------------
    logic [0:15] w0, w1, w2, w3;
    logic [0:15] rot_a, rot_c, f;
    logic [0:63] round_out;

    always_comb begin
        w0        = blk[0:15];
        w1        = blk[16:31];
        w2        = blk[32:47];
        w3        = blk[48:63];
        rot_a     = {w1[1:15], w1[0]};     // rotl1(A), A = W1
        rot_c     = {w3[8:15], w3[0:7]};   // rotl8(C), C = W3
        f         = ~(rot_a & rot_c) ^ rk ^ w3;
        round_out = {w1, w0 ^ f, w3, w2 ^ f};
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        blk_nxt   = blk;
        pout_nxt  = pout;
        rk_idx    = 5'd0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    blk_nxt   = cin;
                    cnt_nxt   = LAST_IDX;
                    state_nxt = RUN;
                end
            end

            RUN: begin
                busy    = 1'b1;
                rk_idx  = cnt;
                blk_nxt = round_out;
                // Exit at zero instead of decrementing, so the counter never
                // wraps. With ROUNDS=1 this is the first and only RUN cycle.
                if (cnt == 5'd0) begin
                    pout_nxt  = round_out;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end

            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            blk   <= 64'd0;
            pout  <= 64'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            blk   <= blk_nxt;
            pout  <= pout_nxt;
        end
    end

endmodule
